axi_mem_responder: RTL

AXI4 responder (slave) that terminates the Rocket `io_mem_axi` master port with an on-chip block-RAM memory, replacing the PS DDR path for standalone boot and simulation. It accepts 64-bit INCR/WRAP/FIXED bursts and serves one transaction at a time. Read and write are arbitrated fairly. It is instantiated in the top-level wrapper in place of the PS `S_AXI` connection, clocked by `host_clk`.

---
 rtl/rc_axi_pkg.sv | 30 +++
 rtl/axi_burst_addr.sv | 40 ++++
 rtl/axi_mem_responder.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/rc_axi_pkg.sv
// rtl/rc_axi_pkg.sv - shared AXI encodings, responder FSM states and burst legality check
// Contents: burst encodings (FIXED/INCR/WRAP), response encodings (OKAY/SLVERR),
//           responder state enum, bad_cfg() burst/size/len legality helper.
package rc_axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_SLVERR = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WDATA,
    ST_WRESP,
    ST_RDATA
  } state_t;

  // Reserved burst type, beats wider than the 64-bit bus, or a WRAP length
  // that does not give a power-of-two window.
  function automatic logic bad_cfg(input logic [1:0] burst,
                                   input logic [2:0] size,
                                   input logic [7:0] len);
    logic wrap_len_ok;
    wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    return (burst == 2'd3) || (size > 3'd3) || ((burst == BURST_WRAP) && !wrap_len_ok);
  endfunction

endpackage

// File: rtl/axi_burst_addr.sv
// rtl/axi_burst_addr.sv - combinational next-beat address for FIXED/INCR/WRAP bursts
// Ports: addr      in  current beat byte address
//        size      in  log2 bytes per beat
//        len       in  beats-1
//        burst     in  burst type
//        next_addr out address of the following beat
module axi_burst_addr #(
  parameter int ADDR_BITS = 32
) (
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [2:0]           size,
  input  logic [7:0]           len,
  input  logic [1:0]           burst,
  output logic [ADDR_BITS-1:0] next_addr
);
  import rc_axi_pkg::*;

  logic [1:0]           sz;
  logic [ADDR_BITS-1:0] step;
  logic [ADDR_BITS-1:0] aligned;
  logic [ADDR_BITS-1:0] bumped;
  logic [ADDR_BITS-1:0] wrap_mask;

  always_comb begin
    // Oversized beats are already flagged as errors; clamp so the shift stays bounded.
    sz        = size[2] ? 2'd3 : size[1:0];
    step      = ADDR_BITS'(1) << sz;
    // An unaligned first beat steps to the next aligned boundary.
    aligned   = addr & ~(step - ADDR_BITS'(1));
    bumped    = aligned + step;
    wrap_mask = ((ADDR_BITS'(len) + ADDR_BITS'(1)) << sz) - ADDR_BITS'(1);
    next_addr = addr;
    case (burst)
      BURST_INCR: next_addr = bumped;
      BURST_WRAP: next_addr = (addr & ~wrap_mask) | (bumped & wrap_mask);
      default:    next_addr = addr;
    endcase
  end

endmodule

// File: rtl/axi_mem_responder.sv
// rtl/axi_mem_responder.sv - AXI4 responder serving one burst at a time from on-chip RAM
// Ports: clock/reset          single clock, asynchronous active-high reset
//        io_axi_aw_*          write address channel (in, ready out)
//        io_axi_w_*           write data channel (in, ready out)
//        io_axi_b_*           write response channel (out, ready in)
//        io_axi_ar_*          read address channel (in, ready out)
//        io_axi_r_*           read data channel (out, ready in)
module axi_mem_responder #(
  parameter int ID_BITS        = 6,
  parameter int ADDR_BITS      = 32,
  parameter int MEM_WORDS_LOG2 = 12
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 io_axi_aw_valid,
  output logic                 io_axi_aw_ready,
  input  logic [ADDR_BITS-1:0] io_axi_aw_bits_addr,
  input  logic [ID_BITS-1:0]   io_axi_aw_bits_id,
  input  logic [7:0]           io_axi_aw_bits_len,
  input  logic [2:0]           io_axi_aw_bits_size,
  input  logic [1:0]           io_axi_aw_bits_burst,
  input  logic                 io_axi_w_valid,
  output logic                 io_axi_w_ready,
  input  logic [63:0]          io_axi_w_bits_data,
  input  logic [7:0]           io_axi_w_bits_strb,
  input  logic                 io_axi_w_bits_last,
  output logic                 io_axi_b_valid,
  input  logic                 io_axi_b_ready,
  output logic [ID_BITS-1:0]   io_axi_b_bits_id,
  output logic [1:0]           io_axi_b_bits_resp,
  input  logic                 io_axi_ar_valid,
  output logic                 io_axi_ar_ready,
  input  logic [ADDR_BITS-1:0] io_axi_ar_bits_addr,
  input  logic [ID_BITS-1:0]   io_axi_ar_bits_id,
  input  logic [7:0]           io_axi_ar_bits_len,
  input  logic [2:0]           io_axi_ar_bits_size,
  input  logic [1:0]           io_axi_ar_bits_burst,
  output logic                 io_axi_r_valid,
  input  logic                 io_axi_r_ready,
  output logic [ID_BITS-1:0]   io_axi_r_bits_id,
  output logic [63:0]          io_axi_r_bits_data,
  output logic [1:0]           io_axi_r_bits_resp,
  output logic                 io_axi_r_bits_last
);
  import rc_axi_pkg::*;

  localparam int MEM_WORDS = 1 << MEM_WORDS_LOG2;

  state_t state, state_next;

  logic                 prio_wr;   // 1: write wins the next AW/AR contention
  logic [ID_BITS-1:0]   txn_id;
  logic [ADDR_BITS-1:0] cur_addr;  // write: beat being accepted; read: next beat to fetch
  logic [7:0]           txn_len;
  logic [2:0]           txn_size;
  logic [1:0]           txn_burst;
  logic [7:0]           beat_cnt;
  logic                 cfg_err;
  logic                 last_err;
  logic                 r_valid_q;
  logic                 r_last_q;

  logic [63:0]          mem [0:MEM_WORDS-1];
  logic [63:0]          ram_q;

  logic                 grant_w, grant_r, contended;
  logic                 aw_hs, ar_hs, w_hs, r_hs;
  logic                 ram_we, ram_re;
  logic [ADDR_BITS-1:0] rd_addr;
  logic [ADDR_BITS-1:0] au_addr, au_next;
  logic [2:0]           au_size;
  logic [7:0]           au_len;
  logic [1:0]           au_burst;

  assign contended = io_axi_aw_valid && io_axi_ar_valid;
  assign grant_w   = io_axi_aw_valid && (!io_axi_ar_valid || prio_wr);
  assign grant_r   = io_axi_ar_valid && (!io_axi_aw_valid || !prio_wr);

  assign aw_hs = io_axi_aw_valid && io_axi_aw_ready;
  assign ar_hs = io_axi_ar_valid && io_axi_ar_ready;
  assign w_hs  = io_axi_w_valid && io_axi_w_ready;
  assign r_hs  = r_valid_q && io_axi_r_ready;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next      = state;
    io_axi_aw_ready = 1'b0;
    io_axi_ar_ready = 1'b0;
    io_axi_w_ready  = 1'b0;
    io_axi_b_valid  = 1'b0;
    case (state)
      ST_IDLE: begin
        // Readies are combinational on the valids; gate them so nothing
        // handshakes while reset is held.
        io_axi_aw_ready = grant_w && !reset;
        io_axi_ar_ready = grant_r && !reset;
        if (io_axi_aw_ready)      state_next = ST_WDATA;
        else if (io_axi_ar_ready) state_next = ST_RDATA;
      end
      ST_WDATA: begin
        io_axi_w_ready = 1'b1;
        if (io_axi_w_valid && (beat_cnt == txn_len)) state_next = ST_WRESP;
      end
      ST_WRESP: begin
        io_axi_b_valid = 1'b1;
        if (io_axi_b_ready) state_next = ST_IDLE;
      end
      ST_RDATA: begin
        if (r_hs && r_last_q) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // ------------------------------------------------------ address unit
  // In IDLE the unit precomputes beat 1 of an incoming read so the first
  // beat can be fetched straight from the AR address.
  always_comb begin
    if (state == ST_IDLE) begin
      au_addr  = io_axi_ar_bits_addr;
      au_size  = io_axi_ar_bits_size;
      au_len   = io_axi_ar_bits_len;
      au_burst = io_axi_ar_bits_burst;
    end else begin
      au_addr  = cur_addr;
      au_size  = txn_size;
      au_len   = txn_len;
      au_burst = txn_burst;
    end
  end

  axi_burst_addr #(.ADDR_BITS(ADDR_BITS)) u_burst_addr (
    .addr      (au_addr),
    .size      (au_size),
    .len       (au_len),
    .burst     (au_burst),
    .next_addr (au_next)
  );

  // ----------------------------------------------------------- datapath
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prio_wr   <= 1'b1;
      txn_id    <= '0;
      cur_addr  <= '0;
      txn_len   <= '0;
      txn_size  <= '0;
      txn_burst <= '0;
      beat_cnt  <= '0;
      cfg_err   <= 1'b0;
      last_err  <= 1'b0;
      r_valid_q <= 1'b0;
      r_last_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (aw_hs) begin
            txn_id    <= io_axi_aw_bits_id;
            cur_addr  <= io_axi_aw_bits_addr;
            txn_len   <= io_axi_aw_bits_len;
            txn_size  <= io_axi_aw_bits_size;
            txn_burst <= io_axi_aw_bits_burst;
            beat_cnt  <= '0;
            cfg_err   <= bad_cfg(io_axi_aw_bits_burst, io_axi_aw_bits_size, io_axi_aw_bits_len);
            last_err  <= 1'b0;
            if (contended) prio_wr <= ~prio_wr;
          end else if (ar_hs) begin
            txn_id    <= io_axi_ar_bits_id;
            cur_addr  <= au_next;
            txn_len   <= io_axi_ar_bits_len;
            txn_size  <= io_axi_ar_bits_size;
            txn_burst <= io_axi_ar_bits_burst;
            beat_cnt  <= '0;
            cfg_err   <= bad_cfg(io_axi_ar_bits_burst, io_axi_ar_bits_size, io_axi_ar_bits_len);
            last_err  <= 1'b0;
            r_valid_q <= 1'b1;
            r_last_q  <= (io_axi_ar_bits_len == 8'd0);
            if (contended) prio_wr <= ~prio_wr;
          end
        end
        ST_WDATA: begin
          if (w_hs) begin
            beat_cnt <= beat_cnt + 8'd1;
            cur_addr <= au_next;
            if (io_axi_w_bits_last != (beat_cnt == txn_len)) last_err <= 1'b1;
          end
        end
        ST_RDATA: begin
          if (r_hs) begin
            if (r_last_q) begin
              r_valid_q <= 1'b0;
              r_last_q  <= 1'b0;
            end else begin
              beat_cnt <= beat_cnt + 8'd1;
              cur_addr <= au_next;
              r_last_q <= ((beat_cnt + 8'd1) == txn_len);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------- RAM
  // Fetch on AR acceptance and on each non-final R handshake only, so the
  // presented beat holds while the master stalls.
  assign rd_addr = (state == ST_IDLE) ? io_axi_ar_bits_addr : cur_addr;
  assign ram_re  = ar_hs || ((state == ST_RDATA) && r_hs && !r_last_q);
  assign ram_we  = w_hs && !cfg_err;

  always_ff @(posedge clock) begin
    if (ram_we) begin
      for (int b = 0; b < 8; b++) begin
        if (io_axi_w_bits_strb[b])
          mem[cur_addr[MEM_WORDS_LOG2+2:3]][8*b +: 8] <= io_axi_w_bits_data[8*b +: 8];
      end
    end
    if (ram_re) ram_q <= mem[rd_addr[MEM_WORDS_LOG2+2:3]];
  end

  // ------------------------------------------------------------ outputs
  assign io_axi_b_bits_id   = txn_id;
  assign io_axi_b_bits_resp = ((state == ST_WRESP) && (cfg_err || last_err)) ? RESP_SLVERR : RESP_OKAY;
  assign io_axi_r_valid     = r_valid_q;
  assign io_axi_r_bits_id   = txn_id;
  assign io_axi_r_bits_last = r_last_q;
  // The RAM output register has no reset; the valid gate keeps data 0 in reset.
  assign io_axi_r_bits_data = (r_valid_q && !cfg_err) ? ram_q : 64'd0;
  assign io_axi_r_bits_resp = (r_valid_q && cfg_err) ? RESP_SLVERR : RESP_OKAY;

endmodule
